// File: rtl/mux8_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux8_sched_pkg
// Brief    : Shared state encodings, defaults and helpers for the 8:1 mux
//            round-robin scheduler.
// Revision : 1.0  initial release
// ============================================================================
package mux8_sched_pkg;

    localparam int unsigned c_hold_max_default = 4;
    localparam int unsigned c_cnt_w            = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    // The mux routes input bit 7 on select 0, so the code is mirrored.
    function automatic logic [2:0] sel_of(input logic [2:0] idx);
        return 3'd7 - idx;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux8_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request bit found
//            scanning upward from ptr, wrapping 7 -> 0.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       valid,
    output logic [2:0] idx
);

    // Scan from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                valid = 1'b1;
                idx   = ptr + 3'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux8_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_scheduler
// Brief    : Round-robin scheduler for an 8:1 mux with per-grant hold limit
//            and a one-cycle gap between grants; all outputs registered.
// Revision : 1.0  initial release
// ============================================================================
module mux8_rr_scheduler
    import mux8_sched_pkg::*;
#(
    parameter int unsigned HOLD_MAX = c_hold_max_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt,
    output logic       busy
);

    localparam logic [c_cnt_w-1:0] c_hold_lim = c_cnt_w'(HOLD_MAX);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [2:0]         r_ptr;
    logic [2:0]         w_ptr_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         r_sel;
    logic [2:0]         w_sel_nxt;
    logic               r_en;
    logic               w_en_nxt;
    logic [7:0]         r_gnt;
    logic [7:0]         w_gnt_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    logic               w_pick_valid;
    logic [2:0]         w_pick_idx;
    logic [2:0]         w_cur_idx;
    logic               w_hold_done;

    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // The registered select already encodes the granted requester.
    assign w_cur_idx   = 3'd7 - r_sel;
    assign w_hold_done = (r_cnt == c_hold_lim);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_en_nxt    = r_en;
        w_gnt_nxt   = r_gnt;
        w_busy_nxt  = r_busy;

        case (r_state)
            IDLE, GAP: begin
                w_state_nxt = IDLE;
                w_en_nxt    = 1'b0;
                w_gnt_nxt   = 8'h00;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_en_nxt    = 1'b1;
                    w_gnt_nxt   = onehot8(w_pick_idx);
                    w_sel_nxt   = sel_of(w_pick_idx);
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = c_cnt_w'(1);
                end
            end
            GRANT: begin
                if (!req[w_cur_idx] || w_hold_done) begin
                    w_state_nxt = GAP;
                    w_en_nxt    = 1'b0;
                    w_gnt_nxt   = 8'h00;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_cur_idx + 3'd1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_en_nxt    = 1'b0;
                w_gnt_nxt   = 8'h00;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_cnt   <= '0;
            r_sel   <= 3'b000;
            r_en    <= 1'b0;
            r_gnt   <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign gnt  = r_gnt;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_rr_scheduler
// Brief    : Directed self-checking bench for mux8_rr_scheduler with
//            HOLD_MAX=4 (dut_a) and HOLD_MAX=1 (dut_b).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux8_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       en_a;
    logic       en_b;
    logic [7:0] gnt_a;
    logic [7:0] gnt_b;
    logic       busy_a;
    logic       busy_b;

    int tests_run = 0;
    int tests_failed = 0;

    mux8_rr_scheduler #(.HOLD_MAX(4)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .req  (req_a),
        .sel  (sel_a),
        .en   (en_a),
        .gnt  (gnt_a),
        .busy (busy_a)
    );

    mux8_rr_scheduler #(.HOLD_MAX(1)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .req  (req_b),
        .sel  (sel_b),
        .en   (en_b),
        .gnt  (gnt_b),
        .busy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++)
            if (g[k]) r = 3'(k);
        return r;
    endfunction

    task automatic check_inv(input string tag, input logic [7:0] g, input logic e, input logic [2:0] s);
        check({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
        check({tag, "_en_or"}, 32'(e), 32'(|g));
        if (e) check({tag, "_sel"}, 32'(s), 32'(3'd7 - idx_of(g)));
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;
        step();
        step();
        check("rst_en",   32'(en_a),   32'd0);
        check("rst_gnt",  32'(gnt_a),  32'h00);
        check("rst_sel",  32'(sel_a),  32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;

        // single requester 0, hold 4 then gap then regrant
        step();
        check("idle_en", 32'(en_a), 32'd0);
        req_a = 8'h01;
        step();
        check("r0_en",   32'(en_a),   32'd1);
        check("r0_gnt",  32'(gnt_a),  32'h01);
        check("r0_sel",  32'(sel_a),  32'd7);
        check("r0_busy", 32'(busy_a), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            step();
            check("r0_hold_en", 32'(en_a), 32'd1);
        end
        step();
        check("r0_gap_en",   32'(en_a),   32'd0);
        check("r0_gap_gnt",  32'(gnt_a),  32'h00);
        check("r0_gap_sel",  32'(sel_a),  32'd7);
        check("r0_gap_busy", 32'(busy_a), 32'd1);
        step();
        check("r0_regrant_gnt", 32'(gnt_a), 32'h01);
        req_a = 8'h00;
        step();
        check("r0_drop_en", 32'(en_a), 32'd0);
        step();
        check("r0_idle_busy", 32'(busy_a), 32'd0);

        // all requesting: order 0..7,0 with 4-cycle grants and 1-cycle gaps
        do_reset();
        req_a = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            step();
            check("ff_gnt", 32'(gnt_a), 32'(8'h01 << (g % 8)));
            check("ff_sel", 32'(sel_a), 32'(7 - (g % 8)));
            check_inv("ff_a", gnt_a, en_a, sel_a);
            for (int c = 0; c < 3; c++) begin
                step();
                check("ff_hold_gnt", 32'(gnt_a), 32'(8'h01 << (g % 8)));
            end
            step();
            check("ff_gap_en", 32'(en_a), 32'd0);
            check("ff_gap_busy", 32'(busy_a), 32'd1);
        end
        req_a = 8'h00;
        step();

        // requester 3 drops early; no preemption; next is first set at/after 4
        do_reset();
        req_a = 8'h08;
        step();
        check("r3_gnt", 32'(gnt_a), 32'h08);
        check("r3_sel", 32'(sel_a), 32'd4);
        req_a = 8'h2C;
        step();
        check("r3_nopreempt_gnt", 32'(gnt_a), 32'h08);
        req_a = 8'h24;
        step();
        check("r3_drop_en",  32'(en_a),  32'd0);
        check("r3_drop_gnt", 32'(gnt_a), 32'h00);
        check("r3_drop_sel", 32'(sel_a), 32'd4);
        step();
        check("r3_next_gnt", 32'(gnt_a), 32'h20);
        check("r3_next_sel", 32'(sel_a), 32'd2);
        req_a = 8'h00;
        step();
        step();

        // requester 7 then wrap to 0
        do_reset();
        req_a = 8'h80;
        step();
        check("r7_gnt", 32'(gnt_a), 32'h80);
        check("r7_sel", 32'(sel_a), 32'd0);
        req_a = 8'h81;
        for (int c = 0; c < 3; c++) step();
        check("r7_hold_gnt", 32'(gnt_a), 32'h80);
        step();
        check("r7_gap_en", 32'(en_a), 32'd0);
        step();
        check("wrap_gnt", 32'(gnt_a), 32'h01);
        check("wrap_sel", 32'(sel_a), 32'd7);
        step();
        check("wrap_hold_en", 32'(en_a), 32'd1);

        // async reset mid-grant
        #3;
        rst = 1'b1;
        #1;
        check("arst_en",   32'(en_a),   32'd0);
        check("arst_gnt",  32'(gnt_a),  32'h00);
        check("arst_sel",  32'(sel_a),  32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        req_a = 8'h30;
        step();
        check("arst_hold_en", 32'(en_a), 32'd0);
        rst = 1'b0;
        step();
        check("arst_next_gnt", 32'(gnt_a), 32'h10);
        check("arst_next_sel", 32'(sel_a), 32'd3);

        // HOLD_MAX=1 alternation
        req_a = 8'h00;
        do_reset();
        req_b = 8'h06;
        for (int k = 0; k < 4; k++) begin
            step();
            check("h1_gnt", 32'(gnt_b), (k % 2 == 0) ? 32'h02 : 32'h04);
            check("h1_sel", 32'(sel_b), (k % 2 == 0) ? 32'd6 : 32'd5);
            check("h1_en",  32'(en_b),  32'd1);
            check_inv("h1_grant", gnt_b, en_b, sel_b);
            step();
            check("h1_gap_en",   32'(en_b),   32'd0);
            check("h1_gap_gnt",  32'(gnt_b),  32'h00);
            check("h1_gap_busy", 32'(busy_b), 32'd1);
            check_inv("h1_gap", gnt_b, en_b, sel_b);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
